// File: rtl/latch_seq_pkg.sv
// Shared types for the latch write sequencer: FSM state encoding.
package latch_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request found
// searching upward from i_ptr+1 and wrapping. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx
);

  int   w_j;
  logic w_found;

  // Walk the requesters in rotated order; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = PW'(w_j);
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_sequencer.sv
// Latch write sequencer: round-robin arbitration of NREQ requesters onto one
// d_latch bank, driving D one cycle ahead of EN and holding it one cycle after.
// Optional readback compare in HOLD is enabled with `define READBACK_CHECK_EN.
//
//  state  | meaning
//  IDLE   | no write in flight; arbitrate pending requests
//  SETUP  | D driven, EN low (setup time for the latch)
//  ENABLE | EN high for EN_CYCLES cycles
//  HOLD   | EN low, D unchanged, done pulse (hold time for the latch)
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    lat_d,
  output logic             lat_en
`ifdef READBACK_CHECK_EN
  ,
  input  logic [DW-1:0]    lat_q,
  output logic             err
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(EN_CYCLES + 1);

  seq_state_t      r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] r_gnt;
  logic [DW-1:0]   r_lat_d;
  logic            r_busy, r_done, r_lat_en;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Next-state logic; ENABLE exits when the down-counter reaches zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = SETUP;
      SETUP:   w_next = ENABLE;
      ENABLE:  if (r_cnt == '0) w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // EN down-counter: loaded in SETUP so ENABLE lasts exactly EN_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= '0;
    else if (r_state == SETUP)                 r_cnt <= CW'(EN_CYCLES - 1);
    else if (r_state == ENABLE && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
  end

  // Grant, data capture and round-robin pointer; D only ever moves on IDLE->SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_lat_d  <= '0;
      r_rr_ptr <= PW'(NREQ - 1);
    end else if (r_state == IDLE && |req) begin
      r_gnt    <= w_grant;
      r_lat_d  <= wdata[int'(w_idx)*DW +: DW];
      r_rr_ptr <= w_idx;
    end else if (r_state == HOLD) begin
      r_gnt    <= '0;
    end
  end

  // Status/strobe outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_lat_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy   <= (w_next != IDLE);
      r_lat_en <= (w_next == ENABLE);
      r_done   <= (w_next == HOLD);
    end
  end

`ifdef READBACK_CHECK_EN
  logic r_err;

  // Compare sampled on the ENABLE->HOLD edge, while the latch is still transparent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (r_state == ENABLE) && (w_next == HOLD) && (lat_q != r_lat_d);
  end

  assign err = r_err;
`endif

  assign gnt    = r_gnt;
  assign busy   = r_busy;
  assign done   = r_done;
  assign lat_d  = r_lat_d;
  assign lat_en = r_lat_en;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer with a behavioural d_latch bank.
module tb_latch_write_sequencer;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic            busy, done, lat_en;
  logic [DW-1:0]   lat_d;
  logic [DW-1:0]   q_bank;
  logic [DW-1:0]   exp_d;
  logic [NREQ-1:0] exp_g;
  int              n_checks;
  int              n_err;

`ifdef READBACK_CHECK_EN
  logic          err;
  logic          force_q;
  logic [DW-1:0] lat_q;
  assign lat_q = force_q ? 8'h00 : q_bank;
`endif

  latch_write_sequencer #(.NREQ(NREQ), .DW(DW), .EN_CYCLES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .lat_d  (lat_d),
    .lat_en (lat_en)
`ifdef READBACK_CHECK_EN
    ,
    .lat_q  (lat_q),
    .err    (err)
`endif
  );

  // Transparent-high latch bank.
  always_latch begin
    if (lat_en) q_bank = lat_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    req      = '0;
    wdata    = '0;
`ifdef READBACK_CHECK_EN
    force_q  = 1'b0;
`endif
    rst_n    = 1'b0;
    #12;
    chk("rst_gnt",    gnt,    0);
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_lat_en", lat_en, 0);
    chk("rst_lat_d",  lat_d,  0);
    step();
    rst_n = 1'b1;
    step();

    // 1 + 3: single write of A5, wdata disturbed during ENABLE
    req = 4'b0001;
    wdata[7:0] = 8'hA5;
    step();
    chk("t1_setup_gnt",  gnt,    4'b0001);
    chk("t1_setup_busy", busy,   1);
    chk("t1_setup_en",   lat_en, 0);
    chk("t1_setup_d",    lat_d,  8'hA5);
    req = 4'b0000;
    step();
    chk("t1_en1", lat_en, 1);
    wdata[7:0] = 8'hFF;
    chk("t3_d_en1", lat_d, 8'hA5);
    step();
    chk("t1_en2", lat_en, 1);
    chk("t3_d_en2", lat_d, 8'hA5);
    step();
    chk("t1_hold_en",   lat_en, 0);
    chk("t1_hold_done", done,   1);
    chk("t1_hold_gnt",  gnt,    4'b0001);
    chk("t1_q",         q_bank, 8'hA5);
    step();
    chk("t1_idle_gnt",  gnt,  0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);
    chk("t3_q_after",   q_bank, 8'hA5);

    // 2: all requesting after a fresh reset -> 0,1,2,3,0 every 5 cycles
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wdata = 32'h44_33_22_11;
    req   = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      exp_d = 8'h11 * 8'((t % 4) + 1);
      step();
      chk("t2_gnt", gnt,   {28'd0, exp_g});
      chk("t2_d",   lat_d, {24'd0, exp_d});
      chk("t2_oh",  32'($onehot(gnt)), 1);
      step();
      chk("t2_oh",  32'($onehot(gnt)), 1);
      step();
      chk("t2_oh",  32'($onehot(gnt)), 1);
      step();
      chk("t2_done", done,   1);
      chk("t2_q",    q_bank, {24'd0, exp_d});
      step();
      chk("t2_idle_gnt", gnt, 0);
      if (t == 4) req = 4'b0000;
    end

    // 4: reset during ENABLE
    req = 4'b0100;
    step();
    chk("t4_gnt", gnt, 4'b0100);
    req = 4'b0000;
    step();
    chk("t4_en", lat_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_en",   lat_en, 0);
    chk("t4_rst_gnt",  gnt,    0);
    chk("t4_rst_busy", busy,   0);
    chk("t4_rst_done", done,   0);
    step();
    chk("t4_no_done", done, 0);
    chk("t4_q_kept",  q_bank, 8'h33);
    rst_n = 1'b1;
    req   = 4'b0101;
    step();
    chk("t4_first_after_rst", gnt, 4'b0001);
    req = 4'b0000;
    step();
    step();
    step();
    chk("t4_done", done, 1);
    step();

    // 5: req dropped one cycle after grant; next grant goes past pointer
    req = 4'b0010;
    step();
    chk("t5_gnt", gnt, 4'b0010);
    req = 4'b1001;
    step();
    step();
    step();
    chk("t5_done", done, 1);
    chk("t5_q",    q_bank, 8'h22);
    step();
    chk("t5_idle", busy, 0);
    step();
    chk("t5_next_gnt", gnt, 4'b1000);
    req = 4'b0000;
    step();
    step();
    step();
    chk("t5_done2", done, 1);
    step();

`ifdef READBACK_CHECK_EN
    // 6: readback mismatch and match
    wdata[7:0] = 8'h3C;
    force_q    = 1'b1;
    req        = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    step();
    chk("t6_done_bad", done, 1);
    chk("t6_err_bad",  err,  1);
    step();
    chk("t6_err_clr",  err,  0);
    force_q = 1'b0;
    req     = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    step();
    chk("t6_done_ok", done, 1);
    chk("t6_err_ok",  err,  0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
